btb_predictor: RTL
==================

Name: btb_predictor

Overview:
- Fetch-stage next-PC predictor; parametrised successor to the decode-stage PC target adder.
- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Registered one-cycle prediction for fetch; trained by resolved branch/jump outcomes from execute.

Parameters:
ENTRIES, 16, number of BTB entries (power of 2, >=2); IDX = log2(ENTRIES)
TAG_BITS, 12, tag width taken from pc[IDX+2 +: TAG_BITS]
CNT_BITS, 2, direction counter width (>=1)
RAS_DEPTH, 4, return-stack depth (used only with BTB_RAS_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
f_valid  in  1  fetch PC valid this cycle
f_pc  in  64  fetch PC
stall  in  1  hold prediction outputs; ignore f_valid
flush  in  1  drop in-flight prediction
pred_valid  out  1  prediction valid
pred_pc  out  64  PC the prediction belongs to
pred_taken  out  1  predicted taken
pred_target  out  64  predicted next PC
upd_valid  in  1  resolved control instruction
upd_pc  in  64  its PC
upd_kind  in  2  br_kind_t: BRANCH=0, JUMP=1, CALL=2, RET=3
upd_taken  in  1  actual direction
upd_target  in  64  actual target

Behaviour:
- Reset: all entry valid bits 0; counters = weakly-not-taken (2^(CNT_BITS-1)-1); pred_valid=0, pred_pc=0, pred_taken=0, pred_target=0.
- Lookup
  - idx = f_pc[IDX+1:2]; hit = entry.valid && entry.tag == f_pc tag bits.
  - Latency 1: a lookup with f_valid=1, stall=0, flush=0 at edge N drives pred_* from edge N+1.
  - A lookup with f_valid=0 (stall=0) sets pred_valid=0.
  - stall=1: all pred_* hold.
  - flush=1: pred_valid=0 next cycle; flush wins over stall.
- Taken rules
  - BRANCH: taken = counter MSB.
  - JUMP, CALL, RET: taken whenever hit.
  - On hit && taken: pred_target = stored target; otherwise pred_target = f_pc+4 and pred_taken=0.
- Update (at edge, upd_valid=1)
  - Hit: counter saturating-increments if upd_taken, else saturating-decrements; no wrap at max or 0.
  - Hit && upd_taken: target and kind rewritten.
  - Miss && upd_taken: allocate; tag, target, kind written; counter = weakly-taken (2^(CNT_BITS-1)); overwrites any prior entry at idx.
  - Miss && !upd_taken: no change.
- Stored target always has bit0 forced to 0.
- Lookup and update to the same idx on one edge: lookup sees pre-update contents (no bypass).
- All arithmetic 64-bit modulo 2^64; f_pc+4 wraps silently.

Optional Feature:
- Macro: BTB_RAS_EN.
- Defined: adds a RAS_DEPTH return-address stack.
  - Accepted lookup that hits a CALL entry pushes f_pc+4.
  - Hit on a RET entry with stack non-empty pops and uses the popped value as pred_target; empty stack falls back to the BTB target.
  - Push when full overwrites the oldest entry (circular, count saturates).
  - flush clears the stack; reset empties it.
  - Stalled cycles neither push nor pop.
- Not defined: CALL behaves as JUMP; RET uses BTB target; no stack state.

Decomposition:
- Shared pipes package:
  - br_kind_t enum.
  - btb_entry_t struct {valid, tag, target, cnt, kind}.
  - Counter init constants.
- One sub-module, ras_stack (push, pop, flush, top, empty), instantiated only under BTB_RAS_EN.

Test Plan:
- Reset, then lookup f_pc=0x8000_0000 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x8000_0004.
- Update BRANCH pc=0x8000_0010, taken, target=0x8000_0100 (CNT_BITS=2) -> lookup 0x8000_0010 gives taken, target 0x8000_0100. Two not-taken updates -> lookup gives not-taken, target 0x8000_0014.
- Four taken updates on one entry -> counter stays 3. Then one not-taken update -> lookup still predicts taken.
- Aliasing: allocate pc=0x40 then pc=0x40+ENTRIES*4 with a different tag (both JUMP, taken) -> lookup 0x40 misses (pred_target 0x44).
- stall=1 for 3 cycles with changing f_pc -> pred_* constant. flush during stall -> pred_valid=0 next cycle.
- BTB_RAS_EN: CALL at 0x100 (target 0x400), RET at 0x404 trained. Lookup 0x100, then 0x404 -> RET prediction 0x104. Five pushes with RAS_DEPTH=4 then five pops -> 4 correct addresses, 5th uses BTB target.

Source files
------------

// File: rtl/btb_predictor_pkg.sv
// -----------------------------------------------------------------------------
// btb_predictor_pkg
// Shared types and constants for the fetch-stage BTB predictor.
//   br_kind_t   : kind of resolved control instruction.
//   btb_entry_t : one BTB entry at the default geometry (12-bit tag, 2-bit
//                 counter). btb_predictor builds a local copy of this record
//                 whose widths follow its parameters.
//   cnt_weak_nt / cnt_weak_t : counter init values for any counter width.
// -----------------------------------------------------------------------------
package btb_predictor_pkg;

   typedef enum logic [1:0] {
      BR_BRANCH = 2'd0,
      BR_JUMP   = 2'd1,
      BR_CALL   = 2'd2,
      BR_RET    = 2'd3
   } br_kind_t;

   localparam int BTB_DEF_TAG_BITS = 12;
   localparam int BTB_DEF_CNT_BITS = 2;

   typedef struct packed {
      logic                        valid;
      logic [BTB_DEF_TAG_BITS-1:0] tag;
      logic [63:0]                 target;
      logic [BTB_DEF_CNT_BITS-1:0] cnt;
      br_kind_t                    kind;
   } btb_entry_t;

   // Weakly-not-taken: just below the MSB threshold.
   function automatic int cnt_weak_nt(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction

   // Weakly-taken: lowest value with the MSB set.
   function automatic int cnt_weak_t(input int bits);
      return 1 << (bits - 1);
   endfunction

endpackage

// File: rtl/btb_predictor_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; the occupancy count saturates at DEPTH. Flush and reset empty
// the stack. Push has priority over pop (the caller never asserts both).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_push        : push i_push_data
//   i_push_data   : return address to push
//   i_pop         : pop top entry (ignored when empty)
//   i_flush       : empty the stack
//   o_top         : current top-of-stack value
//   o_empty       : stack holds no entries
// -----------------------------------------------------------------------------
module ras_stack #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  logic [63:0] i_push_data,
   input  logic        i_pop,
   input  logic        i_flush,
   output logic [63:0] o_top,
   output logic        o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [63:0]   r_mem [DEPTH];
   logic [PW-1:0] r_ptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_ptr_inc;
   logic [PW-1:0] w_ptr_dec;
   logic          w_do_push;
   logic          w_do_pop;

   // Pointer arithmetic wraps at DEPTH, which need not be a power of two.
   assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
   assign w_ptr_dec = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - 1'b1;
   assign w_do_push = i_push && !i_flush;
   assign w_do_pop  = i_pop && !i_flush && !i_push && (r_count != '0);

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (w_do_push) begin
         r_ptr <= w_ptr_inc;
         if (r_count != CW'(DEPTH)) begin
            r_count <= r_count + 1'b1;
         end
      end else if (w_do_pop) begin
         r_ptr   <= w_ptr_dec;
         r_count <= r_count - 1'b1;
      end
   end

   // Storage carries no reset; only the pointer/count define what is live.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[w_ptr_inc] <= i_push_data;
      end
   end

   assign o_top   = r_mem[r_ptr];
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
// Fetch-stage next-PC predictor: direct-mapped BTB with per-entry saturating
// direction counters, registered one-cycle prediction, trained by resolved
// control instructions from execute.
// Optional feature macro: BTB_RAS_EN adds a RAS_DEPTH return-address stack
// (CALL hits push f_pc+4, RET hits pop into pred_target).
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   f_valid, f_pc             : fetch lookup request
//   stall                     : hold all pred_* and ignore f_valid
//   flush                     : drop prediction (wins over stall)
//   pred_valid/pc/taken/target: registered prediction
//   upd_valid/pc/kind/taken/target : resolved outcome used for training
// -----------------------------------------------------------------------------
module btb_predictor
   import btb_predictor_pkg::*;
#(
   parameter int ENTRIES   = 16,
   parameter int TAG_BITS  = 12,
   parameter int CNT_BITS  = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_valid,
   input  logic [63:0] f_pc,
   input  logic        stall,
   input  logic        flush,
   output logic        pred_valid,
   output logic [63:0] pred_pc,
   output logic        pred_taken,
   output logic [63:0] pred_target,
   input  logic        upd_valid,
   input  logic [63:0] upd_pc,
   input  logic [1:0]  upd_kind,
   input  logic        upd_taken,
   input  logic [63:0] upd_target
);

   localparam int IDX = $clog2(ENTRIES);
   localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(cnt_weak_nt(CNT_BITS));
   localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(cnt_weak_t(CNT_BITS));
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [63:0]         target;
      logic [CNT_BITS-1:0] cnt;
      br_kind_t            kind;
   } entry_t;

   entry_t r_btb [ENTRIES];

   logic                r_pred_valid;
   logic [63:0]         r_pred_pc;
   logic                r_pred_taken;
   logic [63:0]         r_pred_target;

   logic [IDX-1:0]      w_f_idx;
   logic [TAG_BITS-1:0] w_f_tag;
   entry_t              w_f_ent;
   logic                w_f_hit;
   logic                w_f_taken;
   logic [63:0]         w_f_seq;
   logic [63:0]         w_f_target;
   logic                w_accept;

   logic [IDX-1:0]      w_u_idx;
   logic [TAG_BITS-1:0] w_u_tag;
   entry_t              w_u_ent;
   logic                w_u_hit;
   logic [63:0]         w_u_target;
   logic                w_unused;

   // ---------------------------------------------------------------- lookup
   assign w_f_idx  = f_pc[IDX+1:2];
   assign w_f_tag  = f_pc[IDX+2 +: TAG_BITS];
   assign w_f_ent  = r_btb[w_f_idx];
   assign w_f_hit  = w_f_ent.valid && (w_f_ent.tag == w_f_tag);
   assign w_f_seq  = f_pc + 64'd4;
   assign w_accept = f_valid && !stall && !flush;

   // Branches follow the counter MSB; every other kind is taken on a hit.
   always_comb begin
      w_f_taken = 1'b0;
      if (w_f_hit) begin
         w_f_taken = (w_f_ent.kind == BR_BRANCH) ? w_f_ent.cnt[CNT_BITS-1] : 1'b1;
      end
   end

`ifdef BTB_RAS_EN
   logic        w_ras_push;
   logic        w_ras_pop;
   logic        w_ras_empty;
   logic [63:0] w_ras_top;

   assign w_ras_push = w_accept && w_f_hit && (w_f_ent.kind == BR_CALL);
   assign w_ras_pop  = w_accept && w_f_hit && (w_f_ent.kind == BR_RET) && !w_ras_empty;

   ras_stack #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_ras_push),
      .i_push_data (w_f_seq),
      .i_pop       (w_ras_pop),
      .i_flush     (flush),
      .o_top       (w_ras_top),
      .o_empty     (w_ras_empty)
   );

   // A RET with an empty stack falls back to its stored BTB target.
   always_comb begin
      w_f_target = w_f_seq;
      if (w_f_taken) begin
         w_f_target = w_ras_pop ? w_ras_top : w_f_ent.target;
      end
   end
`else
   localparam int UNUSED_RAS_DEPTH = RAS_DEPTH;

   always_comb begin
      w_f_target = w_f_taken ? w_f_ent.target : w_f_seq;
   end
`endif

   // ---------------------------------------------------- prediction register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pred_valid  <= 1'b0;
         r_pred_pc     <= '0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= '0;
      end else if (flush) begin
         r_pred_valid <= 1'b0;
      end else if (!stall) begin
         r_pred_valid <= f_valid;
         if (f_valid) begin
            r_pred_pc     <= f_pc;
            r_pred_taken  <= w_f_taken;
            r_pred_target <= w_f_target;
         end
      end
   end

   assign pred_valid  = r_pred_valid;
   assign pred_pc     = r_pred_pc;
   assign pred_taken  = r_pred_taken;
   assign pred_target = r_pred_target;

   // ---------------------------------------------------------------- update
   assign w_u_idx    = upd_pc[IDX+1:2];
   assign w_u_tag    = upd_pc[IDX+2 +: TAG_BITS];
   assign w_u_ent    = r_btb[w_u_idx];
   assign w_u_hit    = w_u_ent.valid && (w_u_ent.tag == w_u_tag);
   assign w_u_target = {upd_target[63:1], 1'b0};

   // The lookup above reads r_btb combinationally before this edge's write,
   // so a same-index lookup sees the pre-update entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT, kind: BR_BRANCH};
         end
      end else if (upd_valid) begin
         if (w_u_hit) begin
            if (upd_taken) begin
               if (w_u_ent.cnt != CNT_MAX) begin
                  r_btb[w_u_idx].cnt <= w_u_ent.cnt + 1'b1;
               end
               r_btb[w_u_idx].target <= w_u_target;
               r_btb[w_u_idx].kind   <= br_kind_t'(upd_kind);
            end else if (w_u_ent.cnt != '0) begin
               r_btb[w_u_idx].cnt <= w_u_ent.cnt - 1'b1;
            end
         end else if (upd_taken) begin
            r_btb[w_u_idx] <= '{valid: 1'b1, tag: w_u_tag, target: w_u_target,
                                cnt: CNT_WT, kind: br_kind_t'(upd_kind)};
         end
      end
   end

   // Low PC bits and bits above the tag never take part in indexing.
   assign w_unused = ^{f_pc, upd_pc, upd_target[0]};

endmodule
